sw_reg_wr: RTL and testbench

SW_REG_WR -- requirements
Module: sw_reg_wr

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wbs_slave_if.sv | 62 ++++++
 rtl/sw_reg_wr.sv | 67 ++++++
 tb/tb_sw_reg_wr.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone helpers: width legality checks, byte-enable width
// derivation and the generic byte-enable merge.
package wb_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_BYTE_EN    = MAX_DATA_WIDTH / 8;

  function automatic bit isLegalDataWidth(input int width);
    return (width == 8) || (width == 16) || (width == 32) || (width == 64);
  endfunction

  function automatic bit isLegalAddrWidth(input int width);
    return (width == 4) || (width == 8) || (width == 16) || (width == 32);
  endfunction

  function automatic int byteEnWidth(input int dataWidth);
    return dataWidth / 8;
  endfunction

  // Works at the widest legal width; callers zero-extend and truncate.
  function automatic logic [MAX_DATA_WIDTH-1:0] byteMerge(
    input logic [MAX_DATA_WIDTH-1:0] oldData,
    input logic [MAX_DATA_WIDTH-1:0] newData,
    input logic [MAX_BYTE_EN-1:0]    byteSel
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = oldData;
    for (int n = 0; n < MAX_BYTE_EN; n++) begin
      if (byteSel[n]) merged[n*8 +: 8] = newData[n*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wbs_slave_if.sv
// Wishbone slave front end: address-window decode and the registered
// ack, which alternates when a request is held.
module wbs_slave_if
  import wb_pkg::*;
#(
  parameter int          BUS_ADDR_WIDTH = 8,
  parameter logic [31:0] DEV_BASE_ADDR  = 32'h0,
  parameter logic [31:0] DEV_HIGH_ADDR  = 32'h0F
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
  output logic                      o_req,
  output logic                      o_wr_en,
  output logic                      wbs_ack_o
);

  localparam logic [BUS_ADDR_WIDTH-1:0] BASE = BUS_ADDR_WIDTH'(DEV_BASE_ADDR);
  localparam logic [BUS_ADDR_WIDTH-1:0] HIGH = BUS_ADDR_WIDTH'(DEV_HIGH_ADDR);

  logic w_geBase;
  logic w_leHigh;
  logic w_req;
  logic r_ack;

  if (!isLegalAddrWidth(BUS_ADDR_WIDTH)) begin : g_badAddrWidth
    $error("wbs_slave_if: BUS_ADDR_WIDTH=%0d is not one of 4, 8, 16, 32", BUS_ADDR_WIDTH);
  end

  if (DEV_BASE_ADDR > DEV_HIGH_ADDR) begin : g_badWindow
    $error("wbs_slave_if: DEV_BASE_ADDR is above DEV_HIGH_ADDR");
  end

  // Bounds that cover the whole address space are tied off so no
  // constant comparison is built.
  if (BASE == '0) begin : g_noLowBound
    assign w_geBase = 1'b1;
  end else begin : g_lowBound
    assign w_geBase = (wbs_adr_i >= BASE);
  end

  if (HIGH == '1) begin : g_noHighBound
    assign w_leHigh = 1'b1;
  end else begin : g_highBound
    assign w_leHigh = (wbs_adr_i <= HIGH);
  end

  assign w_req = wbs_cyc_i & wbs_stb_i & w_geBase & w_leHigh;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_ack <= 1'b0;
    else           r_ack <= w_req & ~r_ack;
  end

  assign o_req     = w_req;
  assign o_wr_en   = w_req & wbs_we_i & ~r_ack;
  assign wbs_ack_o = r_ack;

endmodule

// File: rtl/sw_reg_wr.sv
// Single software-writable register on a Wishbone slave port; every
// decoded address aliases it and its value drives fabric_data_o.
module sw_reg_wr
  import wb_pkg::*;
#(
  parameter int          BUS_DATA_WIDTH = 32,
  parameter int          BUS_ADDR_WIDTH = 8,
  parameter logic [31:0] DEV_BASE_ADDR  = 32'h0,
  parameter logic [31:0] DEV_HIGH_ADDR  = 32'h0F,
  localparam int         BYTE_EN_WIDTH  = byteEnWidth(BUS_DATA_WIDTH)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [BYTE_EN_WIDTH-1:0]  wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0] wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic [BUS_DATA_WIDTH-1:0] fabric_data_o
);

  logic                      w_req;
  logic                      w_wrEn;
  logic [BUS_DATA_WIDTH-1:0] w_merged;
  logic [BUS_DATA_WIDTH-1:0] r_reg;
  logic [BUS_DATA_WIDTH-1:0] r_datOut;

  if (!isLegalDataWidth(BUS_DATA_WIDTH)) begin : g_badDataWidth
    $error("sw_reg_wr: BUS_DATA_WIDTH=%0d is not one of 8, 16, 32, 64", BUS_DATA_WIDTH);
  end

  wbs_slave_if #(
    .BUS_ADDR_WIDTH (BUS_ADDR_WIDTH),
    .DEV_BASE_ADDR  (DEV_BASE_ADDR),
    .DEV_HIGH_ADDR  (DEV_HIGH_ADDR)
  ) u_slaveIf (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .o_req     (w_req),
    .o_wr_en   (w_wrEn),
    .wbs_ack_o (wbs_ack_o)
  );

  assign w_merged = BUS_DATA_WIDTH'(byteMerge(64'(r_reg), 64'(wbs_dat_i), 8'(wbs_sel_i)));

  // Read data captures the pre-write value, so a write ack returns the old contents.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_reg    <= '0;
      r_datOut <= '0;
    end else begin
      if (w_req)  r_datOut <= r_reg;
      if (w_wrEn) r_reg    <= w_merged;
    end
  end

  assign wbs_dat_o     = r_datOut;
  assign fabric_data_o = r_reg;

endmodule

// File: tb/tb_sw_reg_wr.sv
// Directed bench for sw_reg_wr with a cycle-level reference model and
// hand-computed spot checks.
module tb_sw_reg_wr;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [7:0]  adr = 8'h00;
  logic [31:0] datIn = 32'h0;
  logic [31:0] datOut;
  logic        ack;
  logic [31:0] fabric;

  logic [31:0] modelReg = 32'h0;
  logic [31:0] modelDat = 32'h0;
  logic        modelAck = 1'b0;

  int nChecks = 0;
  int nFails  = 0;
  int ackCount;

  sw_reg_wr dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rstN),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (datIn),
    .wbs_dat_o     (datOut),
    .wbs_ack_o     (ack),
    .fabric_data_o (fabric)
  );

  always #5 clk = ~clk;

  // Reference model: a decoded request is acked unless the previous cycle
  // was an ack; an un-acked write updates the selected bytes, and every
  // request captures the register contents seen before that edge.
  always @(posedge clk or negedge rstN) begin
    logic isReq;
    if (!rstN) begin
      modelReg = 32'h0;
      modelDat = 32'h0;
      modelAck = 1'b0;
    end else begin
      isReq = cyc && stb && (adr <= 8'h0F);
      if (isReq) modelDat = modelReg;
      if (isReq && we && !modelAck) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) modelReg[b*8 +: 8] = datIn[b*8 +: 8];
        end
      end
      modelAck = isReq && !modelAck;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, mid-period, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("model_ack",    32'(ack), 32'(modelAck));
    checkOutput("model_dat",    datOut,   modelDat);
    checkOutput("model_fabric", fabric,   modelReg);
  end

  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [3:0] bsel, input logic [7:0] a, input logic [31:0] d);
    cyc = c; stb = s; we = w; sel = bsel; adr = a; datIn = d;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    stepEdge();
  endtask

  initial begin
    #2 rstN = 1'b0;
    repeat (3) stepEdge();
    checkOutput("reset_ack",    32'(ack), 32'h0);
    checkOutput("reset_dat",    datOut,   32'h0);
    checkOutput("reset_fabric", fabric,   32'h0);

    // Write posted while still in reset is serviced on the first edge after release.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hA, 8'h00, 32'hEEEEEEEE);
    @(negedge clk);
    #2 rstN = 1'b1;
    stepEdge();
    checkOutput("wr_sel_a_ack",    32'(ack), 32'h1);
    checkOutput("wr_sel_a_fabric", fabric,   32'hEE00EE00);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
    stepEdge();
    checkOutput("rd_after_sel_a_ack", 32'(ack), 32'h1);
    checkOutput("rd_after_sel_a_dat", datOut,   32'hEE00EE00);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 8'h00, 32'h12345678);
    stepEdge();
    idleCycle();
    applyStimulus(1'b1, 1'b1, 0, 4'hF, 8'h00, 32'h0);
    stepEdge();
    checkOutput("rd_full_word", datOut, 32'h12345678);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 8'h0C, 32'hCAFEF00D);
    stepEdge();
    idleCycle();
    checkOutput("alias_wr_fabric", fabric, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 8'h0C, 32'h0);
    stepEdge();
    checkOutput("alias_rd_dat", datOut, 32'hCAFEF00D);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 8'h10, 32'h00000000);
    for (int i = 0; i < 4; i++) begin
      stepEdge();
      checkOutput("out_of_range_ack", 32'(ack), 32'h0);
    end
    checkOutput("out_of_range_fabric", fabric, 32'hCAFEF00D);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
    ackCount = 0;
    for (int i = 0; i < 4; i++) begin
      stepEdge();
      if (ack) ackCount++;
    end
    checkOutput("held_req_ack_pulses", 32'(ackCount), 32'd2);
    idleCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 8'h00, 32'h000000AB);
    stepEdge();
    idleCycle();
    checkOutput("low_byte_wr_fabric", fabric, 32'hCAFEF0AB);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'hFFFFFFFF);
    stepEdge();
    checkOutput("sel_zero_ack",    32'(ack), 32'h1);
    checkOutput("sel_zero_fabric", fabric,   32'hCAFEF0AB);
    idleCycle();

    // Reset lands between request assertion and the write edge.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 8'h00, 32'h55555555);
    @(negedge clk);
    #2 rstN = 1'b0;
    stepEdge();
    checkOutput("reset_mid_wr_ack",    32'(ack), 32'h0);
    checkOutput("reset_mid_wr_fabric", fabric,   32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    #2 rstN = 1'b1;
    stepEdge();

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 8'h0F, 32'hFFFF1234);
    stepEdge();
    checkOutput("top_addr_ack", 32'(ack), 32'h1);
    idleCycle();
    checkOutput("top_addr_fabric", fabric, 32'h00001234);

    repeat (2) stepEdge();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
